// File: rtl/dac_stream_pkg.sv
// Shared constants, FSM encoding and the idle-code helper for the DAC stream loader.
package dac_stream_pkg;
  localparam int NUM_CH    = 8;
  localparam int DAC_WIDTH = 12;
  localparam int DAC_MIN   = -2048;
  localparam int DAC_MAX   = 2047;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;
  localparam logic [1:0] ST_DROP    = 2'd3;

  // Code that puts the DAC at mid-scale (0 V) for the chosen output format.
  function automatic logic [DAC_WIDTH-1:0] zero_code(input bit offset_binary);
    return offset_binary ? 12'h800 : 12'h000;
  endfunction
endpackage

// File: rtl/dac_sample_conditioner.sv
// Shift, clamp to the 12-bit DAC range and optionally convert to offset binary.
module dac_sample_conditioner import dac_stream_pkg::*; #(
  parameter int IN_WIDTH      = 16,
  parameter int SHIFT         = 0,
  parameter int OFFSET_BINARY = 1
) (
  input  logic [IN_WIDTH-1:0]  tdata,
  output logic [DAC_WIDTH-1:0] code,
  output logic                 sat
);
  localparam logic signed [IN_WIDTH-1:0] VMAX = IN_WIDTH'(DAC_MAX);
  localparam logic signed [IN_WIDTH-1:0] VMIN = IN_WIDTH'(DAC_MIN);

  logic signed [IN_WIDTH-1:0] v;
  logic [DAC_WIDTH-1:0]       c;

  assign v = $signed(tdata) >>> SHIFT;

  always_comb begin
    sat = 1'b0;
    c   = v[DAC_WIDTH-1:0];
    if (v > VMAX) begin
      c   = 12'h7FF;
      sat = 1'b1;
    end else if (v < VMIN) begin
      c   = 12'h800;
      sat = 1'b1;
    end
    code = (OFFSET_BINARY != 0) ? {~c[DAC_WIDTH-1], c[DAC_WIDTH-2:0]} : c;
  end
endmodule

// File: rtl/dac_channel_stream_loader.sv
// AXI-Stream to 8-channel DAC loader: shadow bank filled per beat, committed atomically on tlast.
module dac_channel_stream_loader import dac_stream_pkg::*; #(
  parameter int IN_WIDTH      = 16,
  parameter int SHIFT         = 0,
  parameter int OFFSET_BINARY = 1,
  parameter int FRAME_TIMEOUT = 1000
) (
  input  logic                 aclk,
  input  logic                 resetn,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic [2:0]           s_axis_tdest,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [DAC_WIDTH-1:0] ch0_data,
  output logic [DAC_WIDTH-1:0] ch1_data,
  output logic [DAC_WIDTH-1:0] ch2_data,
  output logic [DAC_WIDTH-1:0] ch3_data,
  output logic [DAC_WIDTH-1:0] ch4_data,
  output logic [DAC_WIDTH-1:0] ch5_data,
  output logic [DAC_WIDTH-1:0] ch6_data,
  output logic [DAC_WIDTH-1:0] ch7_data,
  output logic                 frame_commit,
  output logic [NUM_CH-1:0]    written_mask,
  output logic [NUM_CH-1:0]    sat_flags,
  output logic                 frame_timeout,
  input  logic                 clear_status
);
  localparam logic [DAC_WIDTH-1:0] ZC = zero_code(OFFSET_BINARY != 0);
  localparam int CW = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(FRAME_TIMEOUT - 1);

  logic [NUM_CH-1:0][DAC_WIDTH-1:0] shadow, active;
  logic [NUM_CH-1:0]                pend_mask;
  logic [1:0]                       state, state_nxt;
  logic [CW-1:0]                    tmo_cnt;
  logic [DAC_WIDTH-1:0]             code;
  logic                             sat;
  logic                             acc;

  assign acc = s_axis_tvalid & s_axis_tready;

  dac_sample_conditioner #(
    .IN_WIDTH(IN_WIDTH), .SHIFT(SHIFT), .OFFSET_BINARY(OFFSET_BINARY)
  ) u_cond (
    .tdata(s_axis_tdata), .code(code), .sat(sat)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (acc) state_nxt = s_axis_tlast ? ST_COMMIT : ST_COLLECT;
      ST_COLLECT: begin
        if (acc && s_axis_tlast)          state_nxt = ST_COMMIT;
        else if (!acc && tmo_cnt == TMO_LAST) state_nxt = ST_DROP;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      s_axis_tready <= 1'b0;
      shadow        <= {NUM_CH{ZC}};
      active        <= {NUM_CH{ZC}};
      pend_mask     <= '0;
      tmo_cnt       <= '0;
      frame_commit  <= 1'b0;
      written_mask  <= '0;
      sat_flags     <= '0;
      frame_timeout <= 1'b0;
    end else begin
      state         <= state_nxt;
      // Registered ready: low for the whole commit/drop cycle, no comb path from tvalid.
      s_axis_tready <= (state_nxt == ST_IDLE) || (state_nxt == ST_COLLECT);
      frame_commit  <= 1'b0;

      if (acc) begin
        shadow[s_axis_tdest]    <= code;
        pend_mask[s_axis_tdest] <= 1'b1;
      end

      if (state == ST_COLLECT && !acc) tmo_cnt <= tmo_cnt + 1'b1;
      else                             tmo_cnt <= '0;

      if (state == ST_COMMIT) begin
        active       <= shadow;
        frame_commit <= 1'b1;
        written_mask <= pend_mask;
        pend_mask    <= '0;
      end

      // Restoring shadow from active keeps unwritten channels equal to what the DAC holds.
      if (state == ST_DROP) begin
        shadow    <= active;
        pend_mask <= '0;
      end

      if (state == ST_DROP)  frame_timeout <= 1'b1;
      else if (clear_status) frame_timeout <= 1'b0;

      sat_flags <= (clear_status ? '0 : sat_flags)
                 | ((acc && sat) ? (NUM_CH'(1) << s_axis_tdest) : '0);
    end
  end

  assign ch0_data = active[0];
  assign ch1_data = active[1];
  assign ch2_data = active[2];
  assign ch3_data = active[3];
  assign ch4_data = active[4];
  assign ch5_data = active[5];
  assign ch6_data = active[6];
  assign ch7_data = active[7];
endmodule
